qpsk_symbol_mapper: RTL

Downstream neighbour of the 32-bit-to-2-bit QPSK converter. Accepts one 2-bit QPSK symbol per AXI-Stream beat (bit1 = I bit, bit0 = Q bit) and maps each bit to a signed 16-bit DAC amplitude. Each symbol is emitted SPS times (zero-order hold, or one impulse followed by zero stuffing) as sc16 samples {I,Q}. The output feeds the pulse-shaping/DAC path of the TX chain.

---
 rtl/qpsk_pkg.sv | 23 ++
 rtl/qpsk_symbol_mapper.sv | 63 ++++++
 2 files changed

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared QPSK amplitude constants and sc16 packing helpers
package qpsk_pkg;

   localparam logic [15:0] QPSK_ONE  = 16'h6665;
   localparam logic [15:0] QPSK_ZERO = 16'h999B;

   typedef struct packed {
      logic [15:0] i;
      logic [15:0] q;
   } sc16_t;

   function automatic logic [15:0] map_bit(input logic b);
      return b ? QPSK_ONE : QPSK_ZERO;
   endfunction

   function automatic logic [31:0] pack_sc16(input logic [15:0] i, input logic [15:0] q);
      sc16_t s;
      s.i = i;
      s.q = q;
      return s;
   endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// rtl/qpsk_symbol_mapper.sv - maps 2-bit QPSK symbols to sc16 samples, SPS samples per symbol
module qpsk_symbol_mapper
   import qpsk_pkg::*;
#(
   parameter int          SPS        = 4,
   parameter logic [15:0] ONE        = QPSK_ONE,
   parameter logic [15:0] ZERO       = QPSK_ZERO,
   parameter bit          ZERO_STUFF = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_tdata,
   input  logic        in_tvalid,
   output logic        in_tready,
   output logic [31:0] out_tdata,
   output logic        out_tvalid,
   input  logic        out_tready,
   output logic [31:0] sym_cnt
);

   localparam int REP_W = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(SPS - 1);

   logic             hold_valid;
   logic [REP_W-1:0] rep_cnt;
   logic             xfer;
   logic             last_beat;
   logic             accept;
   logic             unused_upper;

   assign unused_upper = ^in_tdata[31:2];

   assign out_tvalid = hold_valid;
   assign xfer       = out_tvalid && out_tready;
   assign last_beat  = xfer && (rep_cnt == REP_LAST);
   // The only combinational input-to-output path: ready passes through on the final repeat.
   assign in_tready  = !hold_valid || last_beat;
   assign accept     = in_tvalid && in_tready;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid <= 1'b0;
         rep_cnt    <= '0;
         out_tdata  <= 32'h0;
         sym_cnt    <= 32'h0;
      end else if (accept) begin
         out_tdata  <= pack_sc16(in_tdata[1] ? ONE : ZERO, in_tdata[0] ? ONE : ZERO);
         hold_valid <= 1'b1;
         rep_cnt    <= '0;
         sym_cnt    <= sym_cnt + 32'd1;
      end else if (xfer) begin
         if (rep_cnt == REP_LAST) begin
            hold_valid <= 1'b0;
            rep_cnt    <= '0;
         end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
            if (ZERO_STUFF)
               out_tdata <= 32'h0;
         end
      end
   end

endmodule
